// File: rtl/rbe_binconv_block_acc_pkg.sv
// Shared types and constants for the accumulating BinConv block.
// The FSM state type is exported here so a checker can bind on it.
package rbe_binconv_block_acc_pkg;

  localparam int BINCONV_ACC_WIDTH     = 32;
  localparam int BINCONV_ACC_CNT_WIDTH = 8;
  localparam int BINCONV_BLOCK_SIZE    = 4;
  localparam int BINCONV_MAX_SHIFT     = 16;
  localparam int BINCONV_SH_W          = $clog2(BINCONV_MAX_SHIFT) + 1;

  typedef enum logic {
    BC_IDLE  = 1'b0,
    BC_ACCUM = 1'b1
  } binconv_acc_state_e;

  typedef struct packed {
    logic [BINCONV_BLOCK_SIZE-1:0]    sop_mask;
    logic [BINCONV_SH_W-1:0]          shift_base;
    logic                             qa_tile_sel;
    logic [BINCONV_ACC_CNT_WIDTH-1:0] n_acc;
  } ctrl_binconv_acc_t;

  typedef struct packed {
    logic                             busy;
    logic                             ovf;
    logic [BINCONV_ACC_CNT_WIDTH-1:0] cnt;
  } flags_binconv_acc_t;

  // Saturating per-SoP shift: base + SoP index + optional tile offset.
  function automatic int unsigned sat_shift(input int unsigned raw, input int unsigned max_sh);
    return (raw > max_sh) ? max_sh : raw;
  endfunction

endpackage

// File: rtl/rbe_binconv_block_acc_shift_sum.sv
// Combinational BinConv datapath: per-SoP AND-popcount of the incoming beat,
// and the masked shift-and-add of registered popcounts.
module rbe_binconv_shift_sum #(
  parameter int BC_BLOCK_SIZE = 4,
  parameter int TP            = 32,
  parameter int MAX_SHIFT     = 16,
  parameter int ACC_WIDTH     = 32
) (
  input  logic [BC_BLOCK_SIZE*TP-1:0]                   act_i,
  input  logic [TP-1:0]                                 wgt_i,
  output logic [BC_BLOCK_SIZE*($clog2(TP)+1)-1:0]       pc_o,
  input  logic [BC_BLOCK_SIZE*($clog2(TP)+1)-1:0]       pc_i,
  input  logic [BC_BLOCK_SIZE*($clog2(MAX_SHIFT)+1)-1:0] sh_i,
  input  logic [BC_BLOCK_SIZE-1:0]                      mask_i,
  output logic [ACC_WIDTH-1:0]                          sum_o
);

  localparam int POP_W  = $clog2(TP) + 1;
  localparam int SH_W   = $clog2(MAX_SHIFT) + 1;
  localparam int TERM_W = POP_W + MAX_SHIFT;
  localparam int SUM_W  = TERM_W + $clog2(BC_BLOCK_SIZE) + 1;

  function automatic logic [POP_W-1:0] popcnt(input logic [TP-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int b = 0; b < TP; b++) begin
      c = c + POP_W'(v[b]);
    end
    return c;
  endfunction

  always_comb begin
    pc_o = '0;
    for (int i = 0; i < BC_BLOCK_SIZE; i++) begin
      pc_o[i*POP_W +: POP_W] = popcnt(act_i[i*TP +: TP] & wgt_i);
    end
  end

  logic [SUM_W-1:0] sum_wide;

  // Terms are formed at TERM_W so the largest legal shift never truncates.
  always_comb begin
    sum_wide = '0;
    for (int i = 0; i < BC_BLOCK_SIZE; i++) begin
      if (mask_i[i]) begin
        sum_wide = sum_wide + SUM_W'(TERM_W'(pc_i[i*POP_W +: POP_W]) << sh_i[i*SH_W +: SH_W]);
      end
    end
  end

  assign sum_o = ACC_WIDTH'(sum_wide);

endmodule

// File: rtl/rbe_binconv_block_acc.sv
// Accumulating BinConv block: joins activation/weight beats, popcounts and
// shift-sums them, and emits one accumulated result per n_acc-beat window.
module rbe_binconv_block_acc
  import rbe_binconv_block_acc_pkg::*;
#(
  parameter int BC_BLOCK_SIZE = 4,
  parameter int TP            = 32,
  parameter int MAX_SHIFT     = 16,
  parameter int ACC_WIDTH     = 32,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          test_mode_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [BC_BLOCK_SIZE*TP-1:0]   act_data_i,
  input  logic                          act_valid_i,
  output logic                          act_ready_o,
  input  logic [TP-1:0]                 wgt_data_i,
  input  logic                          wgt_valid_i,
  output logic                          wgt_ready_o,
  input  logic [BC_BLOCK_SIZE-1:0]      sop_mask_i,
  input  logic [$clog2(MAX_SHIFT):0]    shift_base_i,
  input  logic                          qa_tile_sel_i,
  input  logic [CNT_WIDTH-1:0]          n_acc_i,
  output logic [ACC_WIDTH-1:0]          pres_data_o,
  output logic                          pres_valid_o,
  input  logic                          pres_ready_i,
  output logic                          busy_o,
  output logic                          ovf_o,
  output flags_binconv_acc_t            dbg_flags_o
);

  localparam int POP_W = $clog2(TP) + 1;
  localparam int SH_W  = $clog2(MAX_SHIFT) + 1;

  // Handshake: a beat transfers on an edge where act_valid_i & wgt_valid_i &
  // in_ready; both readies equal in_ready. The result transfers on
  // pres_valid_o & pres_ready_i, and pres_data_o is stable while valid waits.

  binconv_acc_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           s1_valid_q, s1_valid_d;
  logic                           s1_last_q, s1_last_d;
  logic [BC_BLOCK_SIZE-1:0]       s1_mask_q, s1_mask_d;
  logic [BC_BLOCK_SIZE*POP_W-1:0] s1_pc_q, s1_pc_d;
  logic [BC_BLOCK_SIZE*SH_W-1:0]  s1_sh_q, s1_sh_d;
  logic [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic [ACC_WIDTH-1:0]           pres_data_q, pres_data_d;
  logic                           pres_valid_q, pres_valid_d;
  logic                           ovf_q, ovf_d;

  logic                           stall, in_ready, accept, s2_fire, pop;
  logic [BC_BLOCK_SIZE*POP_W-1:0] pc_comb;
  logic [BC_BLOCK_SIZE*SH_W-1:0]  sh_comb;
  logic [ACC_WIDTH-1:0]           beat_sum, acc_next;
  logic                           carry;
  logic [CNT_WIDTH:0]             cnt_inc, n_eff;
  logic                           beat_last;
  logic                           unused_test_mode;

  assign unused_test_mode = test_mode_i;

  // Only a last beat can be blocked: it needs the output register free.
  assign stall    = s1_valid_q & s1_last_q & pres_valid_q & ~pres_ready_i;
  assign in_ready = enable_i & ~stall;
  assign accept   = act_valid_i & wgt_valid_i & in_ready;
  assign s2_fire  = enable_i & s1_valid_q & ~stall;
  assign pop      = enable_i & pres_valid_q & pres_ready_i;

  assign act_ready_o = in_ready;
  assign wgt_ready_o = in_ready;

  assign n_eff     = (n_acc_i == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, n_acc_i};
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign beat_last = (cnt_inc >= n_eff);

  always_comb begin
    sh_comb = '0;
    for (int i = 0; i < BC_BLOCK_SIZE; i++) begin
      sh_comb[i*SH_W +: SH_W] = SH_W'(sat_shift(int'(shift_base_i) + i + (qa_tile_sel_i ? 4 : 0),
                                                MAX_SHIFT));
    end
  end

  rbe_binconv_shift_sum #(
    .BC_BLOCK_SIZE (BC_BLOCK_SIZE),
    .TP            (TP),
    .MAX_SHIFT     (MAX_SHIFT),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_shift_sum (
    .act_i  (act_data_i),
    .wgt_i  (wgt_data_i),
    .pc_o   (pc_comb),
    .pc_i   (s1_pc_q),
    .sh_i   (s1_sh_q),
    .mask_i (s1_mask_q),
    .sum_o  (beat_sum)
  );

  assign {carry, acc_next} = {1'b0, acc_q} + {1'b0, beat_sum};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    s1_mask_d    = s1_mask_q;
    s1_pc_d      = s1_pc_q;
    s1_sh_d      = s1_sh_q;
    acc_d        = acc_q;
    pres_data_d  = pres_data_q;
    pres_valid_d = pres_valid_q;
    ovf_d        = ovf_q;

    case (state_q)
      BC_IDLE: begin
        if (accept) state_d = BC_ACCUM;
      end
      BC_ACCUM: begin
        if (!accept && s2_fire && s1_last_q) state_d = BC_IDLE;
      end
      default: state_d = BC_IDLE;
    endcase

    if (accept) begin
      cnt_d      = beat_last ? '0 : cnt_inc[CNT_WIDTH-1:0];
      s1_valid_d = 1'b1;
      s1_last_d  = beat_last;
      s1_mask_d  = sop_mask_i;
      s1_pc_d    = pc_comb;
      s1_sh_d    = sh_comb;
    end else if (s2_fire) begin
      s1_valid_d = 1'b0;
    end

    if (pop) pres_valid_d = 1'b0;

    // A closing beat hands its sum to the output and restarts the window.
    if (s2_fire) begin
      ovf_d = ovf_q | carry;
      if (s1_last_q) begin
        pres_data_d  = acc_next;
        pres_valid_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BC_IDLE;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mask_q    <= '0;
      s1_pc_q      <= '0;
      s1_sh_q      <= '0;
      acc_q        <= '0;
      pres_data_q  <= '0;
      pres_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (clear_i) begin
      state_q      <= BC_IDLE;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mask_q    <= '0;
      s1_pc_q      <= '0;
      s1_sh_q      <= '0;
      acc_q        <= '0;
      pres_data_q  <= '0;
      pres_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (enable_i) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_mask_q    <= s1_mask_d;
      s1_pc_q      <= s1_pc_d;
      s1_sh_q      <= s1_sh_d;
      acc_q        <= acc_d;
      pres_data_q  <= pres_data_d;
      pres_valid_q <= pres_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pres_data_o  = pres_data_q;
  assign pres_valid_o = pres_valid_q;
  assign busy_o       = (state_q == BC_ACCUM);
  assign ovf_o        = ovf_q;

  assign dbg_flags_o.busy = busy_o;
  assign dbg_flags_o.ovf  = ovf_q;
  assign dbg_flags_o.cnt  = BINCONV_ACC_CNT_WIDTH'(cnt_q);

endmodule

// File: tb/tb_rbe_binconv_block_acc.sv
// Bench for rbe_binconv_block_acc: a 32-bit and a 10-bit accumulator instance
// share stimulus; a model pushes expected window sums that a monitor pops.
module tb_rbe_binconv_block_acc;
  import rbe_binconv_block_acc_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i = 1'b1;
  logic         test_mode_i = 1'b0;
  logic         enable_i = 1'b1;
  logic         clear_i = 1'b0;
  logic [127:0] act_data_i = '0;
  logic         act_valid_i = 1'b0;
  logic [31:0]  wgt_data_i = '0;
  logic         wgt_valid_i = 1'b0;
  logic [3:0]   sop_mask_i = '0;
  logic [4:0]   shift_base_i = '0;
  logic         qa_tile_sel_i = 1'b0;
  logic [7:0]   n_acc_i = 8'd1;
  logic         pres_ready_i = 1'b1;

  logic               act_ready_o, wgt_ready_o, pres_valid_o, busy_o, ovf_o;
  logic [31:0]        pres_data_o;
  flags_binconv_acc_t dbg_w;
  logic               act_ready_n, wgt_ready_n, pres_valid_n, busy_n, ovf_n;
  logic [9:0]         pres_data_n;
  flags_binconv_acc_t dbg_n;

  rbe_binconv_block_acc dut (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(test_mode_i), .enable_i(enable_i),
    .clear_i(clear_i), .act_data_i(act_data_i), .act_valid_i(act_valid_i),
    .act_ready_o(act_ready_o), .wgt_data_i(wgt_data_i), .wgt_valid_i(wgt_valid_i),
    .wgt_ready_o(wgt_ready_o), .sop_mask_i(sop_mask_i), .shift_base_i(shift_base_i),
    .qa_tile_sel_i(qa_tile_sel_i), .n_acc_i(n_acc_i), .pres_data_o(pres_data_o),
    .pres_valid_o(pres_valid_o), .pres_ready_i(pres_ready_i), .busy_o(busy_o),
    .ovf_o(ovf_o), .dbg_flags_o(dbg_w)
  );

  rbe_binconv_block_acc #(.ACC_WIDTH(10)) dut_n (
    .clk_i(clk), .rst_i(rst_i), .test_mode_i(test_mode_i), .enable_i(enable_i),
    .clear_i(clear_i), .act_data_i(act_data_i), .act_valid_i(act_valid_i),
    .act_ready_o(act_ready_n), .wgt_data_i(wgt_data_i), .wgt_valid_i(wgt_valid_i),
    .wgt_ready_o(wgt_ready_n), .sop_mask_i(sop_mask_i), .shift_base_i(shift_base_i),
    .qa_tile_sel_i(qa_tile_sel_i), .n_acc_i(n_acc_i), .pres_data_o(pres_data_n),
    .pres_valid_o(pres_valid_n), .pres_ready_i(pres_ready_i), .busy_o(busy_n),
    .ovf_o(ovf_n), .dbg_flags_o(dbg_n)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [9:0]  exp10_q[$];
  logic [63:0] m_acc = '0;
  int          m_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic model_beat(input logic [127:0] act, input logic [31:0] wgt, input logic [3:0] mask,
                            input logic [4:0] base, input logic qa, input logic [7:0] nacc);
    logic [63:0] bs;
    int          sh, pc, nn;
    bs = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        pc = $countones(act[i*32 +: 32] & wgt);
        sh = int'(base) + i + (qa ? 4 : 0);
        if (sh > 16) sh = 16;
        bs = bs + (64'(pc) << sh);
      end
    end
    m_acc = m_acc + bs;
    m_cnt++;
    nn = (nacc == 0) ? 1 : int'(nacc);
    if (m_cnt >= nn) begin
      exp_q.push_back(m_acc[31:0]);
      exp10_q.push_back(m_acc[9:0]);
      model_reset();
    end
  endtask

  // driver: called at a negedge, returns at the negedge after the accepting edge
  task automatic drive_beat(input logic [127:0] act, input logic [31:0] wgt, input logic [3:0] mask,
                            input logic [4:0] base, input logic qa, input logic [7:0] nacc);
    int t;
    t = 0;
    act_data_i = act; wgt_data_i = wgt; sop_mask_i = mask;
    shift_base_i = base; qa_tile_sel_i = qa; n_acc_i = nacc;
    act_valid_i = 1'b1; wgt_valid_i = 1'b1;
    if (rand_ready) pres_ready_i = 1'($urandom_range(0, 1));
    #1;
    while (!(act_ready_o && wgt_ready_o) && t < 100) begin
      @(negedge clk);
      if (rand_ready) pres_ready_i = 1'($urandom_range(0, 1));
      #1;
      t++;
    end
    check("accept_wait", 64'(t < 100), 64'd1);
    if (t < 100) model_beat(act, wgt, mask, base, qa, nacc);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    act_valid_i = 1'b0;
    wgt_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp10_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size() + exp10_q.size()), 64'd0);
  endtask

  // output monitor: samples just before the edge that transfers the result
  always @(negedge clk) begin
    #2;
    if (!rst_i && !clear_i && enable_i && pres_ready_i) begin
      if (pres_valid_o) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(pres_data_o), 64'hffff_ffff_ffff_ffff);
        else check("pres_data", 64'(pres_data_o), 64'(exp_q.pop_front()));
      end
      if (pres_valid_n) begin
        if (exp10_q.size() == 0) check("unexpected_out_n", 64'(pres_data_n), 64'hffff_ffff_ffff_ffff);
        else check("pres_data_n", 64'(pres_data_n), 64'(exp10_q.pop_front()));
      end
    end
  end

  logic [127:0] ones_a;
  logic [31:0]  ones_w;

  initial begin
    ones_a = '1;
    ones_w = '1;

    @(negedge clk);
    #1;
    check("rst_valid", 64'(pres_valid_o), 64'd0);
    check("rst_data", 64'(pres_data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_ready", 64'(act_ready_o), 64'd1);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // single beat, latency
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd1);
    idle();
    #1;
    check("lat_e0_valid", 64'(pres_valid_o), 64'd0);
    @(posedge clk);
    #1;
    check("lat_e1_valid", 64'(pres_valid_o), 64'd1);
    check("lat_e1_data", 64'(pres_data_o), 64'd480);
    @(negedge clk);
    wait_drain();

    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b1, 8'd1);
    drive_beat(ones_a, ones_w, 4'b0101, 5'd0, 1'b0, 8'd1);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd0);
    idle();
    wait_drain();

    // three-beat window and busy span
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    #1;
    check("busy_first", 64'(busy_o), 64'd1);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    #1;
    check("busy_last_s1", 64'(busy_o), 64'd1);
    @(posedge clk);
    #1;
    check("busy_done", 64'(busy_o), 64'd0);
    check("win3_data", 64'(pres_data_o), 64'd1440);
    @(negedge clk);
    wait_drain();

    // back-pressure across two windows
    pres_ready_i = 1'b0;
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd1);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd1);
    idle();
    #1;
    check("bp_ready_low", 64'(act_ready_o), 64'd0);
    check("bp_hold_data", 64'(pres_data_o), 64'd480);
    repeat (3) @(negedge clk);
    #1;
    check("bp_still_valid", 64'(pres_valid_o), 64'd1);
    check("bp_still_low", 64'(wgt_ready_o), 64'd0);
    @(negedge clk);
    pres_ready_i = 1'b1;
    wait_drain();

    // random windows with random result back-pressure
    rand_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      logic [7:0] nacc;
      nacc = 8'($urandom_range(0, 3));
      for (int b = 0; b < ((nacc == 0) ? 1 : int'(nacc)); b++) begin
        drive_beat({$urandom, $urandom, $urandom, $urandom}, $urandom, 4'($urandom_range(0, 15)),
                   5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), nacc);
      end
    end
    idle();
    rand_ready = 1'b0;
    pres_ready_i = 1'b1;
    wait_drain();

    // reset mid-window
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    rst_i = 1'b1;
    #1;
    check("rstmw_busy", 64'(busy_o), 64'd0);
    check("rstmw_data", 64'(pres_data_o), 64'd0);
    check("rstmw_cnt", 64'(dbg_w.cnt), 64'd0);
    check("rstmw_ovf_n", 64'(ovf_n), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    for (int b = 0; b < 3; b++) drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    wait_drain();

    // clear mid-window
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_reset();
    #1;
    check("clr_busy", 64'(busy_o), 64'd0);
    check("clr_data", 64'(pres_data_o), 64'd0);
    check("clr_valid", 64'(pres_valid_o), 64'd0);
    @(negedge clk);
    for (int b = 0; b < 3; b++) drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    wait_drain();

    // enable low mid-window holds the partial sum
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    enable_i = 1'b0;
    #1;
    check("en_ready_low", 64'(act_ready_o), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("en_busy_held", 64'(busy_o), 64'd1);
    @(negedge clk);
    enable_i = 1'b1;
    drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd3);
    idle();
    wait_drain();

    // wrap and sticky overflow on the 10-bit instance
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_reset();
    #1;
    check("ovf_n_cleared", 64'(ovf_n), 64'd0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) drive_beat(ones_a, ones_w, 4'b1111, 5'd0, 1'b0, 8'd4);
    idle();
    wait_drain();
    repeat (2) @(negedge clk);
    #1;
    check("ovf_n_set", 64'(ovf_n), 64'd1);
    check("ovf_w_clear", 64'(ovf_o), 64'd0);
    check("wrap_data_n", 64'(pres_data_n), 64'd896);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    check("ovf_n_after_clr", 64'(ovf_n), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rbe_binconv_block_acc.md
Name: rbe_binconv_block_acc

Overview:
Parametrised next-generation BinConv block. It takes one binary TP-bit weight vector per beat and BC_BLOCK_SIZE binary TP-bit activation vectors. For each SoP it computes the AND-popcount, scales it by a per-SoP shift, and sums only the unmasked SoPs. Unlike the previous block, it accumulates the sums in-block over a programmable number of beats. It emits one ACC_WIDTH result per accumulation window over a valid/ready handshake with full back-pressure. It sits between the activation/weight streamers and the block-level output accumulator of the RBE engine.

Parameters:
BC_BLOCK_SIZE, 4, number of SoPs per block
TP, 32, bits per activation/weight vector
MAX_SHIFT, 16, largest per-SoP shift amount allowed
ACC_WIDTH, 32, accumulator and output width
CNT_WIDTH, 8, width of the accumulation-length field
POP_W, $clog2(TP)+1 (localparam), popcount width
SH_W, $clog2(MAX_SHIFT)+1 (localparam), shift field width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
test_mode_i  in  1  test mode (no functional effect)
enable_i  in  1  global enable; 0 freezes all registers and forces ready low
clear_i  in  1  synchronous clear of all state
act_data_i  in  BC_BLOCK_SIZE*TP  activation vectors, SoP i at [i*TP +: TP]
act_valid_i  in  1  activation valid
act_ready_o  out  1  activation ready
wgt_data_i  in  TP  weight vector, shared by all SoPs
wgt_valid_i  in  1  weight valid
wgt_ready_o  out  1  weight ready
sop_mask_i  in  BC_BLOCK_SIZE  1 = SoP contributes
shift_base_i  in  SH_W  base shift
qa_tile_sel_i  in  1  adds 4 to every shift
n_acc_i  in  CNT_WIDTH  beats per output; 0 is treated as 1
pres_data_o  out  ACC_WIDTH  accumulated result
pres_valid_o  out  1  result valid
pres_ready_i  in  1  result ready
busy_o  out  1  accumulation in progress
ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset (rst_i=1, asynchronous) and clear_i (synchronous, highest priority after reset) drive all of the following to 0: pres_data_o, pres_valid_o, busy_o, ovf_o, beat counter, accumulator, stage-1 register. The FSM returns to IDLE.
- Join rule: a beat is accepted when act_valid_i & wgt_valid_i & in_ready. Both act_ready_o and wgt_ready_o equal in_ready, so one stream's ready never depends on its own valid.
- in_ready = enable_i & ~stall.
- stall = s1_valid & s1_last & pres_valid_o & ~pres_ready_i, i.e. the last beat of a window is blocked while the output register is occupied.
- Stage 1, registered on accept:
  - pc[i] = popcount(act[i] & wgt), POP_W bits.
  - sh[i] = shift_base_i + i + 4*qa_tile_sel_i, clamped to MAX_SHIFT.
  - The mask and the last-beat flag are captured with the data.
  - Control inputs are sampled only on accept.
- Stage 2, on the cycle after stage 1 is valid and not stalled:
  - sum = sum over unmasked i of (pc[i] << sh[i]), zero-extended to ACC_WIDTH.
  - acc_next = acc + sum, modulo 2^ACC_WIDTH.
  - A carry out of acc_next sets ovf_o (sticky until clear/reset).
- FSM states:
  - IDLE: busy_o=0; on accept go to ACCUM and set cnt=1.
  - ACCUM: busy_o=1. Each accept increments cnt. When cnt reaches max(n_acc_i,1), that beat is flagged last and cnt resets to 0.
  - When stage 2 processes a last beat, acc_next is written to pres_data_o and pres_valid_o is set; acc restarts at 0. The FSM returns to IDLE unless a new beat is accepted in the same cycle, in which case it stays in ACCUM.
- Latency:
  - Last beat accepted at edge E0; pres_valid_o rises after edge E1 (2 cycles).
  - Throughput is 1 beat/cycle with no bubbles between windows while the output drains.
- Output handshake:
  - pres_valid_o is held with stable data until pres_valid_o & pres_ready_i.
  - A pop and a new result in the same cycle load the new result; valid stays 1.
- n_acc_i=1: every beat produces one output.
- enable_i=0 mid-window: state is held; the accumulation resumes without loss.

Decomposition:
- rbe_package gains:
  - typedef ctrl_binconv_acc_t {sop_mask, shift_base, qa_tile_sel, n_acc}
  - typedef flags_binconv_acc_t {busy, ovf, cnt}
  - constants BINCONV_ACC_WIDTH=32 and BINCONV_ACC_CNT_WIDTH=8
- One sub-module, rbe_binconv_shift_sum: a combinational popcount + shift + masked adder tree, reusable by the accumulator.

Test Plan:
- TP=32, BC=4, all act/wgt bits 1, mask 4'b1111, shift_base 0, n_acc 1 -> pres_data_o=480, pres_valid_o 2 cycles after accept.
- Same stimulus with qa_tile_sel 1 -> 7680. Mask 4'b0101 with qa_tile_sel 0 -> 160.
- n_acc 3, three back-to-back all-ones beats -> a single output of 1440. busy_o is 1 from the first accept until the last beat is processed. n_acc 0 behaves as n_acc 1.
- pres_ready_i held 0 across two completed windows -> the first result stays stable, ready drops when the second last beat reaches stage 1, and no data is lost; releasing ready delivers 480 then 480.
- ACC_WIDTH=10, n_acc 4 with all-ones beats -> the result wraps modulo 1024 and ovf_o stays 1 until clear_i.
- Reset and clear mid-window: assert rst_i after 2 of 3 beats -> all outputs 0 and IDLE. A fresh window then yields 1440 with no residue. Repeat using clear_i and enable_i=0 pulses.
